// File: rtl/xor_syndrome_pkg.sv
// xor_syndrome_pkg
// Shared constants, helpers and the default-width result bundle for the
// masked XOR syndrome pipeline and the popcount tree it uses.
//   clog2     : ceiling log2, usable in constant expressions
//   weight_w  : number of bits needed to hold a popcount of 0..width
//   syn_result_t : result bundle (diff, weight, parity, zero) at the default width
package xor_syndrome_pkg;

  localparam int DEF_WIDTH  = 23;
  localparam int DEF_STAGES = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A popcount of WIDTH bits ranges 0..WIDTH, hence WIDTH+1 distinct values.
  function automatic int weight_w(input int width);
    return clog2(width + 1);
  endfunction

  localparam int DEF_WW = weight_w(DEF_WIDTH);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] diff;
    logic [DEF_WW-1:0]    weight;
    logic                 parity;
    logic                 zero;
  } syn_result_t;

endpackage

// File: rtl/xor_syndrome_pipe_popcount_tree.sv
// popcount_tree
// Purely combinational population count; shared with the correction block.
//   din   [WIDTH-1:0] : vector to count
//   count [WW-1:0]    : number of ones in din (never overflows)
module popcount_tree
  import xor_syndrome_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WW    = weight_w(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [WW-1:0]    count
);

  // Written as a linear sum; synthesis rebalances it into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + WW'(din[i]);
    end
  end

endmodule

// File: rtl/xor_syndrome_pipe.sv
// xor_syndrome_pipe
// Pipelined masked XOR comparator for the decoder datapath. Each accepted
// transaction yields diff = (a ^ b) & mask plus its Hamming weight, parity and
// zero flag, carried through STAGES register slots with valid/ready flow control.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : input handshake
//   in_a, in_b, in_mask        : operands and per-bit enable
//   out_valid/out_ready        : output handshake
//   out_diff/weight/parity/zero: result bundle from the last slot
//   stat_clr, err_count        : mismatch counter clear / value
// Build option: define XOR_SYNDROME_STATS_EN to enable the saturating mismatch
// counter; otherwise err_count is tied to 0 and stat_clr is ignored.
module xor_syndrome_pipe
  import xor_syndrome_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = 16,
  localparam int WW    = weight_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic [WW-1:0]    out_weight,
  output logic             out_parity,
  output logic             out_zero,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic [WW-1:0]    weight;
    logic             parity;
    logic             zero;
  } bundle_t;

  logic [WIDTH-1:0] in_diff;
  logic [WW-1:0]    in_weight;
  bundle_t          in_res;
  bundle_t          slot [1:STAGES];
  logic [STAGES:1]  v;
  logic [STAGES:1]  adv;

  assign in_diff = (in_a ^ in_b) & in_mask;

  popcount_tree #(.WIDTH(WIDTH), .WW(WW)) u_popcount (
    .din   (in_diff),
    .count (in_weight)
  );

  always_comb begin
    in_res.diff   = in_diff;
    in_res.weight = in_weight;
    in_res.parity = in_weight[0];
    in_res.zero   = (in_weight == '0);
  end

  // Ready chain from the output back: a slot may load when it is empty or when
  // its occupant moves on this cycle, so bubbles collapse.
  always_comb begin
    adv         = '0;
    adv[STAGES] = !v[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  assign in_ready = adv[1];

  // Payload only loads when the upstream slot actually holds data, so an
  // empty slot keeps its last contents instead of toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 1; k <= STAGES; k++) slot[k] <= '0;
    end else begin
      if (adv[1]) begin
        v[1] <= in_valid;
        if (in_valid) slot[1] <= in_res;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) slot[k] <= slot[k-1];
        end
      end
    end
  end

  assign out_valid  = v[STAGES];
  assign out_diff   = slot[STAGES].diff;
  assign out_weight = slot[STAGES].weight;
  assign out_parity = slot[STAGES].parity;
  assign out_zero   = slot[STAGES].zero;

`ifdef XOR_SYNDROME_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear has priority over a same-cycle increment; count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stat_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && !out_zero && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_count = cnt_q;
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign err_count       = '0;
`endif

endmodule

// File: tb/tb_xor_syndrome_pipe.sv
module tb_xor_syndrome_pipe;
  import xor_syndrome_pkg::*;

  localparam int W  = 23;
  localparam int WW = weight_w(W);
`ifdef XOR_SYNDROME_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  typedef struct packed {
    logic [W-1:0]  diff;
    logic [WW-1:0] weight;
    logic          parity;
    logic          zero;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  in_mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_diff;
  logic [WW-1:0] out_weight;
  logic          out_parity;
  logic          out_zero;
  logic          stat_clr = 1'b0;
  logic [CW-1:0] err_count;

  exp_t          sb [$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            outs = 0;
  logic [CW-1:0] exp_err = '0;

  xor_syndrome_pipe #(.WIDTH(W), .STAGES(2), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_weight (out_weight),
    .out_parity (out_parity),
    .out_zero   (out_zero),
    .stat_clr   (stat_clr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] m);
    exp_t r;
    r.diff   = (a ^ b) & m;
    r.weight = WW'($countones(r.diff));
    r.parity = ^r.diff;
    r.zero   = (r.diff == '0);
    return r;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("err_count", err_count, exp_err);
      if (out_valid && sb.size() > 0) chk("held_diff", out_diff, sb[0].diff);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("out_diff", out_diff, e.diff);
          chk("out_weight", out_weight, e.weight);
          chk("out_parity", out_parity, e.parity);
          chk("out_zero", out_zero, e.zero);
          outs++;
`ifdef XOR_SYNDROME_STATS_EN
          if (!e.zero && exp_err != {CW{1'b1}}) exp_err = exp_err + 1'b1;
`endif
        end
      end
`ifdef XOR_SYNDROME_STATS_EN
      if (stat_clr) exp_err = '0;
`endif
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_mask));
    end else begin
      exp_err = '0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_a = a; in_b = b; in_mask = m; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    int idx;
    int outs0;
    logic acc;

    // Reset / idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_diff", out_diff, '0);
    chk("rst_err_count", err_count, '0);
    @(posedge clk); #1;

    // Single transaction, latency 2
    out_ready = 1'b1;
    in_a = 23'h7FFFFF; in_b = '0; in_mask = 23'h7FFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_cycle1_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_cycle2_valid", out_valid, 1'b1);
    chk("single_diff", out_diff, 23'h7FFFFF);
    chk("single_weight", out_weight, 23);
    chk("single_parity", out_parity, 1'b1);
    chk("single_zero", out_zero, 1'b0);
    drain();

    // Masking and equal operands
    send(23'h00000F, 23'h000000, 23'h000003);
    send(23'h2AAAAA, 23'h2AAAAA, 23'h7FFFFF);
    drain();

    // Random back-to-back traffic
    for (int i = 0; i < 12; i++) send(W'($urandom), W'($urandom), W'($urandom));
    drain();

    // Backpressure: 4 vectors, out_ready held low for 5 cycles
    va[0] = 23'h000001; vb[0] = 23'h000000;
    va[1] = 23'h123456; vb[1] = 23'h654321;
    va[2] = 23'h000000; vb[2] = 23'h000000;
    va[3] = 23'h7F0000; vb[3] = 23'h00FFFF;
    outs0 = outs;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_a = va[idx]; in_b = vb[idx]; in_mask = 23'h7FFFFF; in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_a = va[idx]; in_b = vb[idx]; in_mask = 23'h7FFFFF; in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_out_count", outs - outs0, 4);

    // Reset mid-stream with 2 items in flight
    out_ready = 1'b0;
    send(23'h000101, 23'h000000, 23'h7FFFFF);
    send(23'h000303, 23'h000000, 23'h7FFFFF);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_diff", out_diff, '0);
    sb.delete();
    outs0 = outs;
    in_a = 23'h7FFFFF; in_mask = 23'h7FFFFF; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_items", outs - outs0, 0);

`ifdef XOR_SYNDROME_STATS_EN
    // 5 transfers, 3 nonzero
    send(23'h000001, 23'h000000, 23'h7FFFFF);
    send(23'h000005, 23'h000005, 23'h7FFFFF);
    send(23'h0F0000, 23'h000000, 23'h7FFFFF);
    send(23'h0000FF, 23'h000000, 23'h000000);
    send(23'h400000, 23'h000000, 23'h7FFFFF);
    drain();
    chk("stats_three", err_count, 3);
    // Drive to saturation and beyond
    for (int i = 0; i < 13; i++) send(23'h000001, 23'h000000, 23'h7FFFFF);
    drain();
    chk("stats_sat", err_count, {CW{1'b1}});
    send(23'h000002, 23'h000000, 23'h7FFFFF);
    drain();
    chk("stats_sat_hold", err_count, {CW{1'b1}});
    // Clear together with a nonzero transfer
    out_ready = 1'b0;
    send(23'h000004, 23'h000000, 23'h7FFFFF);
    @(posedge clk); #1;
    chk("stats_held_valid", out_valid, 1'b1);
    stat_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("stats_clr_wins", err_count, '0);
`else
    send(23'h000001, 23'h000000, 23'h7FFFFF);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    drain();
    chk("nostats_count_zero", err_count, '0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
